// File: rtl/ysyx_24090018_pkg.sv
// Shared defaults and requester ids for the register-file writeback arbiter.
package ysyx_24090018_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 5;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NREG_DEF       = 16;

  typedef enum logic {
    SRC_EXU = 1'b0,
    SRC_LSU = 1'b1
  } src_e;

endpackage

// File: rtl/ysyx_24090018_scoreboard.sv
// Busy-bit scoreboard: one bit per tracked register, set on issue, cleared on writeback.
module ysyx_24090018_scoreboard
  import ysyx_24090018_pkg::*;
#(
  parameter int unsigned NREG = NREG_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     set_en,
  input  logic [$clog2(NREG)-1:0]  set_idx,
  input  logic                     clr_en,
  input  logic [$clog2(NREG)-1:0]  clr_idx,
  output logic [NREG-1:0]          busy
);

  logic [NREG-1:0] busy_q, busy_d;

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_idx] = 1'b0;
    if (set_en) busy_d[set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/ysyx_24090018_rf_wb_arbiter.sv
// Round-robin EXU/LSU writeback arbiter, registered RF write stage and issue hazard check.
// Define YSYX_24090018_WB_BYPASS_EN to forward the pending write and skip its RAW stall.
module ysyx_24090018_rf_wb_arbiter
  import ysyx_24090018_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NREG       = NREG_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic [ADDR_WIDTH-1:0] issue_rs1,
  input  logic [ADDR_WIDTH-1:0] issue_rs2,
  output logic                  issue_stall,
  input  logic                  exu_valid,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  output logic                  exu_ready,
  input  logic                  lsu_valid,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  lsu_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [DATA_WIDTH-1:0] byp_data
);

  localparam int unsigned IdxW = $clog2(NREG);

  src_e                  last_q, last_d;
  logic                  grant_exu, grant_lsu, xfer;
  logic [ADDR_WIDTH-1:0] xfer_rd;
  logic [DATA_WIDTH-1:0] xfer_data;
  logic                  rf_wen_q;
  logic [ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0] rf_wdata_q;
  logic [NREG-1:0]       busy;
  logic                  hit1, hit2, raw1, raw2, waw;

  // On a tie the side that did not win the most recent transfer is granted.
  always_comb begin
    grant_exu = 1'b0;
    grant_lsu = 1'b0;
    if (!rst) begin
      if (exu_valid && lsu_valid) begin
        grant_exu = (last_q == SRC_LSU);
        grant_lsu = (last_q == SRC_EXU);
      end else begin
        grant_exu = exu_valid;
        grant_lsu = lsu_valid;
      end
    end
  end

  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;
  assign xfer      = grant_exu || grant_lsu;
  assign xfer_rd   = grant_lsu ? lsu_rd : exu_rd;
  assign xfer_data = grant_lsu ? lsu_data : exu_data;

  always_comb begin
    last_d = last_q;
    if (grant_exu) begin
      last_d = SRC_EXU;
    end else if (grant_lsu) begin
      last_d = SRC_LSU;
    end
  end

  // Writes to x0 are accepted but never raise rf_wen.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= SRC_LSU;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      last_q   <= last_d;
      rf_wen_q <= xfer && (xfer_rd != '0);
      if (xfer) begin
        rf_waddr_q <= xfer_rd;
        rf_wdata_q <= xfer_data;
      end
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

  ysyx_24090018_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .set_en  (issue_valid && !issue_stall && (issue_rd != '0)),
    .set_idx (issue_rd[IdxW-1:0]),
    .clr_en  (rf_wen_q),
    .clr_idx (rf_waddr_q[IdxW-1:0]),
    .busy    (busy)
  );

`ifdef YSYX_24090018_WB_BYPASS_EN
  assign hit1     = rf_wen_q && (issue_rs1 == rf_waddr_q) && (issue_rs1 != '0);
  assign hit2     = rf_wen_q && (issue_rs2 == rf_waddr_q) && (issue_rs2 != '0);
  assign byp_data = rf_wdata_q;
`else
  assign hit1     = 1'b0;
  assign hit2     = 1'b0;
  assign byp_data = '0;
`endif

  assign byp_hit1 = hit1;
  assign byp_hit2 = hit2;

  // Lookups use only the low index bits, so x(n) and x(n+16) alias.
  assign raw1 = (issue_rs1 != '0) && busy[issue_rs1[IdxW-1:0]] && !hit1;
  assign raw2 = (issue_rs2 != '0) && busy[issue_rs2[IdxW-1:0]] && !hit2;
  assign waw  = (issue_rd != '0) && busy[issue_rd[IdxW-1:0]];

  assign issue_stall = !rst && issue_valid && (raw1 || raw2 || waw);

endmodule

// File: tb/tb_ysyx_24090018_rf_wb_arbiter.sv
// Directed vector table plus randomized run against a behavioural scoreboard/arbiter model.
module tb_ysyx_24090018_rf_wb_arbiter;

`ifdef YSYX_24090018_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic        ev;
    logic [4:0]  erd;
    logic [31:0] edat;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldat;
    logic        iv;
    logic [4:0]  ird, irs1, irs2;
    logic        x_er, x_lr, x_st, x_wen;
    logic [4:0]  x_waddr;
    logic [31:0] x_wdata;
    logic        x_bh1;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid, issue_stall;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [31:0] exu_data, lsu_data;
  logic        rf_wen, byp_hit1, byp_hit2;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, byp_data;

  always #5 clk = ~clk;

  ysyx_24090018_rf_wb_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_rs1   (issue_rs1),
    .issue_rs2   (issue_rs2),
    .issue_stall (issue_stall),
    .exu_valid   (exu_valid),
    .exu_rd      (exu_rd),
    .exu_data    (exu_data),
    .exu_ready   (exu_ready),
    .lsu_valid   (lsu_valid),
    .lsu_rd      (lsu_rd),
    .lsu_data    (lsu_data),
    .lsu_ready   (lsu_ready),
    .rf_wen      (rf_wen),
    .rf_waddr    (rf_waddr),
    .rf_wdata    (rf_wdata),
    .byp_hit1    (byp_hit1),
    .byp_hit2    (byp_hit2),
    .byp_data    (byp_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int r, input int ev, input int erd, input int ed,
                              input int lv, input int lrd, input int ld, input int iv,
                              input int ird, input int rs1, input int rs2, input int er,
                              input int lr, input int st, input int wen, input int wa,
                              input int wd, input int bh);
    vec_t v;
    v.rst = r[0];     v.ev = ev[0];       v.erd = erd[4:0];   v.edat = ed;
    v.lv = lv[0];     v.lrd = lrd[4:0];   v.ldat = ld;        v.iv = iv[0];
    v.ird = ird[4:0]; v.irs1 = rs1[4:0];  v.irs2 = rs2[4:0];
    v.x_er = er[0];   v.x_lr = lr[0];     v.x_st = st[0];     v.x_wen = wen[0];
    v.x_waddr = wa[4:0];  v.x_wdata = wd;  v.x_bh1 = bh[0];
    return v;
  endfunction

  task automatic drive(input vec_t v);
    rst = v.rst;
    exu_valid = v.ev;  exu_rd = v.erd;  exu_data = v.edat;
    lsu_valid = v.lv;  lsu_rd = v.lrd;  lsu_data = v.ldat;
    issue_valid = v.iv;  issue_rd = v.ird;  issue_rs1 = v.irs1;  issue_rs2 = v.irs2;
  endtask

  // Behavioural model state
  bit          m_busy[16];
  int          m_last;  // 0: EXU won the last transfer, 1: LSU
  bit          m_wen;
  int          m_waddr;
  logic [31:0] m_wdata;

  task automatic model_reset();
    foreach (m_busy[k]) m_busy[k] = 1'b0;
    m_last = 1;  m_wen = 1'b0;  m_waddr = 0;  m_wdata = '0;
  endtask

  initial begin
    vec_t z, cur;
    int   bi = int'(BYP);
    int   nb = int'(!BYP);
    bit   e_won, l_won;

    z = mk(1, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0,0,0,0,0);
    drive(z);
    repeat (2) @(posedge clk);

    //          rst ev erd edat          lv lrd ldat iv ird rs1 rs2  er lr st wen wa wd bh1
    tbl.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 3, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 5, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 11,   1, 2, 22, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 33,   1, 2, 22, 0, 0, 0, 0,  0, 1, 0, 1, 1, 11, 0));
    tbl.push_back(mk(0, 1, 3, 33,   1, 4, 44, 0, 0, 0, 0,  1, 0, 0, 1, 2, 22, 0));
    tbl.push_back(mk(0, 0, 0, 0,    1, 4, 44, 0, 0, 0, 0,  0, 1, 0, 1, 3, 33, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 4, 44, 0));
    tbl.push_back(mk(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 7, 0, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 8, 7, 0,  0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 7, 77,   0, 0, 0,  1, 8, 7, 0,  1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 8, 7, 0,  0, 0, nb, 1, 7, 77, bi));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 9, 7, 0,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 8, 0, 0,  0, 0, bi, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 3, 3,    0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 3, 0, 0,  0, 0, 0, 1, 3, 3, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 3, 0, 0,  0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 19, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  1, 1, 0, 24, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 9, 99,   0, 0, 0,  0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0,    0, 0, 0,  1, 3, 0, 0,  0, 0, 0, 1, 9, 99, 0));
    tbl.push_back(mk(0, 1, 2, 2,    1, 4, 4,  1, 3, 8, 9,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,    1, 4, 4,  0, 0, 0, 0,  0, 1, 0, 1, 2, 2, 0));
    tbl.push_back(mk(0, 0, 0, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 1, 4, 4, 0));

    foreach (tbl[i]) begin
      @(posedge clk);
      #1 drive(tbl[i]);
      @(negedge clk);
      chk($sformatf("row%0d exu_ready", i), 32'(exu_ready), 32'(tbl[i].x_er));
      chk($sformatf("row%0d lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].x_lr));
      chk($sformatf("row%0d issue_stall", i), 32'(issue_stall), 32'(tbl[i].x_st));
      chk($sformatf("row%0d rf_wen", i), 32'(rf_wen), 32'(tbl[i].x_wen));
      chk($sformatf("row%0d byp_hit1", i), 32'(byp_hit1), 32'(tbl[i].x_bh1));
      if (tbl[i].x_wen) begin
        chk($sformatf("row%0d rf_waddr", i), 32'(rf_waddr), 32'(tbl[i].x_waddr));
        chk($sformatf("row%0d rf_wdata", i), rf_wdata, tbl[i].x_wdata);
      end
    end

    // Randomized run; requesters hold their request until granted.
    @(posedge clk);
    #1 drive(z);
    model_reset();
    cur = z;
    e_won = 1'b1;
    l_won = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bit x_er, x_lr, x_st, bh1, bh2, raw1, raw2, waw;
      int rd;
      @(posedge clk);
      #1;
      cur.rst = ($urandom_range(0, 63) == 0);
      if (!cur.ev || e_won) begin
        cur.ev   = ($urandom_range(0, 2) != 0);
        cur.erd  = 5'($urandom_range(0, 7) | (($urandom_range(0, 3) == 0) ? 16 : 0));
        cur.edat = $urandom;
      end
      if (!cur.lv || l_won) begin
        cur.lv   = ($urandom_range(0, 2) != 0);
        cur.lrd  = 5'($urandom_range(0, 7) | (($urandom_range(0, 3) == 0) ? 16 : 0));
        cur.ldat = $urandom;
      end
      cur.iv   = ($urandom_range(0, 1) != 0);
      cur.ird  = 5'($urandom_range(0, 7) | (($urandom_range(0, 3) == 0) ? 16 : 0));
      cur.irs1 = 5'($urandom_range(0, 9));
      cur.irs2 = 5'($urandom_range(0, 9) | (($urandom_range(0, 3) == 0) ? 16 : 0));
      drive(cur);
      @(negedge clk);

      x_er = !cur.rst && cur.ev && (!cur.lv || m_last == 1);
      x_lr = !cur.rst && cur.lv && (!cur.ev || m_last == 0);
      bh1  = BYP && m_wen && (int'(cur.irs1) == m_waddr) && (cur.irs1 != 0);
      bh2  = BYP && m_wen && (int'(cur.irs2) == m_waddr) && (cur.irs2 != 0);
      raw1 = (cur.irs1 != 0) && m_busy[cur.irs1 % 16] && !bh1;
      raw2 = (cur.irs2 != 0) && m_busy[cur.irs2 % 16] && !bh2;
      waw  = (cur.ird != 0) && m_busy[cur.ird % 16];
      x_st = !cur.rst && cur.iv && (raw1 || raw2 || waw);

      chk("rand exu_ready", 32'(exu_ready), 32'(x_er));
      chk("rand lsu_ready", 32'(lsu_ready), 32'(x_lr));
      chk("rand issue_stall", 32'(issue_stall), 32'(x_st));
      chk("rand rf_wen", 32'(rf_wen), 32'(m_wen));
      chk("rand byp_hit1", 32'(byp_hit1), 32'(bh1));
      chk("rand byp_hit2", 32'(byp_hit2), 32'(bh2));
      if (m_wen) begin
        chk("rand rf_waddr", 32'(rf_waddr), 32'(m_waddr));
        chk("rand rf_wdata", rf_wdata, m_wdata);
      end
      if (m_wen || !BYP) chk("rand byp_data", byp_data, BYP ? m_wdata : 32'h0);

      e_won = x_er;
      l_won = x_lr;
      if (cur.rst) begin
        model_reset();
      end else begin
        if (m_wen) m_busy[m_waddr % 16] = 1'b0;
        if (cur.iv && !x_st && cur.ird != 0) m_busy[cur.ird % 16] = 1'b1;
        if (x_er || x_lr) begin
          rd     = x_er ? int'(cur.erd) : int'(cur.lrd);
          m_last = x_er ? 0 : 1;
          m_wen  = (rd != 0);
          if (rd != 0) begin
            m_waddr = rd;
            m_wdata = x_er ? cur.edat : cur.ldat;
          end
        end else begin
          m_wen = 1'b0;
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_24090018_rf_wb_arbiter.md
YSYX_24090018_RF_WB_ARBITER -- requirements
Module: ysyx_24090018_rf_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 5, register-index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, register data width.
REQ-003 SHALL have parameter NREG, default 16, number of tracked registers (index = low 4 bits of any register index).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  clock, all state updates on posedge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 issue_valid  in  1  decode stage presents an instruction.
REQ-008 issue_rd / issue_rs1 / issue_rs2  in  ADDR_WIDTH each  destination and source indices.
REQ-009 issue_stall  out  1  instruction must hold; combinational.
REQ-010 exu_valid, exu_rd[ADDR_WIDTH], exu_data[DATA_WIDTH]  in  ALU writeback request; exu_ready  out  1.
REQ-011 lsu_valid, lsu_rd[ADDR_WIDTH], lsu_data[DATA_WIDTH]  in  load writeback request; lsu_ready  out  1.
REQ-012 rf_wen  out  1, rf_waddr  out  ADDR_WIDTH, rf_wdata  out  DATA_WIDTH  registered register-file write port.
REQ-013 byp_hit1, byp_hit2  out  1 each, byp_data  out  DATA_WIDTH  forwarding of pending write to rs1/rs2.

Function
REQ-014 SHALL grant at most one requester per cycle; ready asserted combinationally for the granted side only; transfer = valid && ready.
REQ-015 One requester valid: it SHALL be granted the same cycle.
REQ-016 Both valid: grant the side not granted by the most recent transfer (round-robin); last-grant pointer updates only on transfer.
REQ-017 Requesters SHALL hold valid, rd, data stable until ready; the arbiter never drops a presented request.
REQ-018 Transfer SHALL load the write stage at the next posedge: rf_waddr/rf_wdata = granted rd/data; latency request-to-rf_wen = 1 cycle.
REQ-019 rf_wen SHALL be 1 only in the cycle after a transfer with rd != 0; rd == 0 transfers are accepted and discarded.
REQ-020 Scoreboard busy[NREG-1:0]: set busy[issue_rd[3:0]] at posedge when issue_valid && !issue_stall && issue_rd != 0.
REQ-021 Scoreboard clear: busy[rf_waddr[3:0]] cleared at posedge when rf_wen = 1.
REQ-022 Set and clear of the same index in one cycle: set SHALL win.
REQ-023 issue_stall = issue_valid && (RAW on rs1, RAW on rs2, or WAW on rd), where a hit requires index != 0 and busy set.
REQ-024 WAW stall guarantees at most one outstanding producer per register; no counter overflow possible.
REQ-025 Index bit 4 SHALL be ignored for scoreboard lookup, matching 16-entry storage.

Reset
REQ-026 rst SHALL clear busy to all 0, rf_wen 0, rf_waddr 0, rf_wdata 0, byp_* 0, last-grant pointer = LSU (EXU wins first tie).
REQ-027 While rst = 1, exu_ready, lsu_ready and issue_stall SHALL be 0; requests presented during rst are not transferred.
REQ-028 rst mid-operation SHALL discard the pending write stage without an rf write.

Configuration
REQ-029 Macro YSYX_24090018_WB_BYPASS_EN defined: a source index matching rf_waddr with rf_wen = 1 SHALL not cause RAW stall; byp_hit1/byp_hit2 = match, byp_data = rf_wdata.
REQ-030 Macro undefined: no bypass; byp_hit1, byp_hit2, byp_data tied 0; RAW stall until busy clears.

Structure
REQ-031 Shared package ysyx_24090018_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, NREG defaults and the requester-id enum (SRC_EXU, SRC_LSU).
REQ-032 Scoreboard SHALL be a sub-module ysyx_24090018_scoreboard (set/clear ports, busy vector out); arbiter and write stage remain in the top.

Verification
REQ-033 EXU valid rd=5 data=0xDEADBEEF alone -> exu_ready same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF.
REQ-034 EXU and LSU both valid 3 cycles after reset -> grants EXU, LSU, EXU in order; the other ready stays 0 each cycle.
REQ-035 Issue rd=7 accepted, then issue rs1=7 -> issue_stall=1 until cycle after rf_wen for rd 7 (bypass off) / during rf_wen cycle stall=0, byp_hit1=1 (bypass on).
REQ-036 Writeback rd=0 data=0x1234 -> ready=1, rf_wen stays 0, busy unchanged.
REQ-037 Issue rd=3 in same cycle as rf_wen clearing rd 3 -> busy[3]=1 afterward; later issue rd=3 stalls (WAW).
REQ-038 rst asserted while write stage holds rd=9 -> rf_wen=0 next cycle, busy all 0, next tie grants EXU.
